// File: rtl/router_input_unit.sv
// Mesh router input port: flit FIFO, XY route on each head flit, request/grant to the switch arbiter.
// Head written at edge t: route registered at t+1, request from the following cycle; backpressure via in_ready (full).
module router_input_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REGISTER = 3,
    parameter int DEPTH      = 4,
    parameter int COORD_W    = 2,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_REGISTER-1:0] request,
    input  logic                  grant,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic                  err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [COORD_W-1:0]    MX   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0]    MYC  = COORD_W'(MY_Y);
    localparam logic [N_REGISTER-1:0] RQ_L = N_REGISTER'(1);
    localparam logic [N_REGISTER-1:0] RQ_N = N_REGISTER'(2);
    localparam logic [N_REGISTER-1:0] RQ_E = N_REGISTER'(3);
    localparam logic [N_REGISTER-1:0] RQ_S = N_REGISTER'(4);
    localparam logic [N_REGISTER-1:0] RQ_W = N_REGISTER'(5);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    state_t                r_state;
    logic [N_REGISTER-1:0] r_route;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] w_head;
    logic [1:0]            w_type;
    logic [COORD_W-1:0]    w_dst_x;
    logic [COORD_W-1:0]    w_dst_y;
    logic                  w_not_empty;
    logic                  w_is_head;
    logic                  w_is_tail;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;
    logic [N_REGISTER-1:0] w_route;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_type      = w_head[DATA_WIDTH-1 -: 2];
    assign w_dst_x     = w_head[2*COORD_W-1:COORD_W];
    assign w_dst_y     = w_head[COORD_W-1:0];
    assign w_not_empty = (r_count != '0);
    assign w_is_head   = w_type[0];
    assign w_is_tail   = w_type[1];

    assign in_ready = (r_count != CW'(DEPTH));
    assign request  = (r_state == S_ACTIVE && w_not_empty) ? r_route : '0;
    assign flit_out = w_not_empty ? w_head : '0;
    assign err      = r_err;

    // A non-head flit at the front while idle has no route, so it is discarded.
    assign w_drop = (r_state == S_IDLE) && w_not_empty && !w_is_head;
    assign w_push = in_valid && in_ready;
    assign w_pop  = (grant && (request != '0)) || w_drop;

    always_comb begin
        w_route = RQ_L;
        if (w_dst_x > MX)
            w_route = RQ_E;
        else if (w_dst_x < MX)
            w_route = RQ_W;
        else if (w_dst_y > MYC)
            w_route = RQ_N;
        else if (w_dst_y < MYC)
            w_route = RQ_S;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_route <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_drop;
            case (r_state)
                S_IDLE: begin
                    if (w_not_empty && w_is_head) begin
                        r_route <= w_route;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_pop && w_is_tail)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit at MY=(1,1), DEPTH=4: per-cycle vector table plus corner sequences.
module tb_router_input_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_flit;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] request;
    logic       grant;
    logic [7:0] flit_out;
    logic       err;

    always #5 clk = ~clk;

    router_input_unit #(
        .DATA_WIDTH(8), .N_REGISTER(3), .DEPTH(4), .COORD_W(2), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .request(request), .grant(grant), .flit_out(flit_out), .err(err)
    );

    typedef struct {
        logic [7:0] flit;
        logic       vld;
        logic       gnt;
        logic       exp_rdy;
        logic [2:0] exp_req;
        logic [7:0] exp_flit;
        logic       exp_err;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] f, input logic v, input logic g,
                       input logic rdy, input logic [2:0] rq, input logic [7:0] fo, input logic e);
        vec_t t;
        t.flit = f; t.vld = v; t.gnt = g;
        t.exp_rdy = rdy; t.exp_req = rq; t.exp_flit = fo; t.exp_err = e;
        tbl.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] f, input logic v, input logic g);
        in_flit  = f;
        in_valid = v;
        grant    = g;
    endtask

    int n_err;

    initial begin
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset in_ready", 8'(in_ready), 8'h01);
        chk("reset request", 8'(request), 8'h00);
        chk("reset flit_out", flit_out, 8'h00);
        chk("reset err", 8'(err), 8'h00);
        rst = 1'b0;

        // Inputs applied before an edge; expected outputs just after it.
        // Single-flit packet 0xF0 -> W(5), then grant in IDLE has no effect.
        add(8'hF0, 1'b1, 1'b0, 1'b1, 3'd0, 8'hF0, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'hF0, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
        // 3-flit packet to E(3), grant held off then one pop per granted cycle.
        add(8'h5D, 1'b1, 1'b0, 1'b1, 3'd0, 8'h5D, 1'b0);
        add(8'h2A, 1'b1, 1'b0, 1'b1, 3'd3, 8'h5D, 1'b0);
        add(8'h95, 1'b1, 1'b0, 1'b1, 3'd3, 8'h5D, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h5D, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h2A, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h95, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        // Fill to DEPTH, 5th flit held; pop while full frees a slot without pushing.
        add(8'h4F, 1'b1, 1'b0, 1'b1, 3'd0, 8'h4F, 1'b0);
        add(8'h01, 1'b1, 1'b0, 1'b1, 3'd3, 8'h4F, 1'b0);
        add(8'h02, 1'b1, 1'b0, 1'b1, 3'd3, 8'h4F, 1'b0);
        add(8'h03, 1'b1, 1'b0, 1'b0, 3'd3, 8'h4F, 1'b0);
        add(8'h84, 1'b1, 1'b0, 1'b0, 3'd3, 8'h4F, 1'b0);
        add(8'h84, 1'b1, 1'b1, 1'b1, 3'd3, 8'h01, 1'b0);
        add(8'h84, 1'b1, 1'b0, 1'b0, 3'd3, 8'h01, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h02, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h03, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h84, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        // Body in IDLE is dropped with an err pulse.
        add(8'h3C, 1'b1, 1'b0, 1'b1, 3'd0, 8'h3C, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1);
        // Local destination -> L(1); grant on empty FIFO mid-packet pops nothing.
        add(8'h45, 1'b1, 1'b0, 1'b1, 3'd0, 8'h45, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h45, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
        add(8'h85, 1'b1, 1'b0, 1'b1, 3'd1, 8'h85, 1'b0);
        add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].flit, tbl[i].vld, tbl[i].gnt);
            tick();
            chk($sformatf("v%0d in_ready", i), 8'(in_ready), 8'(tbl[i].exp_rdy));
            chk($sformatf("v%0d request", i), 8'(request), 8'(tbl[i].exp_req));
            chk($sformatf("v%0d flit_out", i), flit_out, tbl[i].exp_flit);
            chk($sformatf("v%0d err", i), 8'(err), 8'(tbl[i].exp_err));
        end

        // Body 0x00 in IDLE: exactly one err cycle, never a request.
        drive(8'h00, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b0, 1'b0);
        n_err = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (err) n_err++;
            chk($sformatf("drop c%0d request", i), 8'(request), 8'h00);
        end
        chk("drop err pulse count", 8'(n_err), 8'h01);
        chk("drop flit_out empty", flit_out, 8'h00);

        // Tail pop followed by a queued head: one IDLE cycle, then the new route.
        drive(8'hF0, 1'b1, 1'b1);
        tick();
        drive(8'h5D, 1'b1, 1'b1);
        tick();
        chk("b2b first request", 8'(request), 8'h05);
        drive(8'h00, 1'b0, 1'b1);
        tick();
        chk("b2b idle gap request", 8'(request), 8'h00);
        chk("b2b next head on flit_out", flit_out, 8'h5D);
        drive(8'h00, 1'b0, 1'b0);
        tick();
        chk("b2b second request", 8'(request), 8'h03);
        drive(8'h00, 1'b0, 1'b1);
        tick();

        // Asynchronous reset mid-packet, asserted between clock edges.
        drive(8'h2A, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b0, 1'b0);
        chk("pre-reset request", 8'(request), 8'h03);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst in_ready", 8'(in_ready), 8'h01);
        chk("async rst request", 8'(request), 8'h00);
        chk("async rst flit_out", flit_out, 8'h00);
        chk("async rst err", 8'(err), 8'h00);
        tick();
        rst = 1'b0;
        drive(8'h45, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b0, 1'b0);
        chk("post-rst push request", 8'(request), 8'h00);
        tick();
        chk("post-rst routed request", 8'(request), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
